branch_predictor: RTL and testbench
===================================

BRANCH_PREDICTOR -- requirements
Module: branch_predictor

Interface
REQ-001 Parameter WIDTH, default 32, address/data width.
REQ-002 Parameter ENTRIES, default 16, pattern history table depth; power of two, >= 2.
REQ-003 Parameter CNT_BITS, default 2, saturating counter width; >= 1.
REQ-004 Parameter GHR_BITS, default 0, global history length; 0 = bimodal, else gshare; <= log2(ENTRIES).
REQ-005 clk  in  1  single clock; all state updates on rising edge.
REQ-006 rst  in  1  asynchronous, active-high reset.
REQ-007 PCF  in  WIDTH  fetch-stage PC.
REQ-008 InstrF  in  32  fetch-stage instruction.
REQ-009 stall  in  1  hazard stall; freezes fetch/decode.
REQ-010 BranchE  in  1  execute-stage instruction is conditional branch.
REQ-011 TakenE  in  1  resolved branch outcome.
REQ-012 PCTargetE  in  WIDTH  resolved branch target.
REQ-013 PCPlus4E  in  WIDTH  execute-stage PC + 4.
REQ-014 PCBPUSrc  out  1  1 = PC mux selects PCBPU.
REQ-015 PCBPU  out  WIDTH  redirect PC.
REQ-016 flushBranch  out  1  mispredict; flush fetch/decode registers.

Function
REQ-017 Table: ENTRIES counters of CNT_BITS; predict taken when counter MSB = 1.
REQ-018 Index = PCF[log2(ENTRIES)+1:2] XOR zero-extended GHR (GHR_BITS=0: XOR omitted).
REQ-019 B-type (opcode 1100011) at F, predicted taken: PCBPUSrc=1, PCBPU=PCF+B-imm (sign-extended, modulo 2^WIDTH).
REQ-020 JAL (opcode 1101111) at F: always predicted taken, PCBPU=PCF+J-imm; no table access or update.
REQ-021 Other opcodes, incl. JALR, or B-type predicted not-taken: PCBPUSrc=0 unless REQ-025 applies.
REQ-022 Per-fetch metadata {valid, pred_taken, index} registered F->D on each edge with stall=0; held when stall=1.
REQ-023 Metadata D->E registered each edge; bubble (valid=0) loaded when stall=1 or flushBranch=1.
REQ-024 flushBranch=1 also clears D-stage metadata valid on the same edge.
REQ-025 Mispredict (combinational, execute): BranchE & valid_E & (TakenE != pred_taken_E) -> flushBranch=1, PCBPUSrc=1, PCBPU = TakenE ? PCTargetE : PCPlus4E.
REQ-026 Mispredict overrides any simultaneous fetch prediction; stall never suppresses flushBranch.
REQ-027 Update on edge when BranchE & valid_E: counter[index_E] +1 if TakenE else -1; saturate at 2^CNT_BITS-1 and 0.
REQ-028 GHR (GHR_BITS>0) updated non-speculatively on same event: shift left, LSB=TakenE.
REQ-029 Prediction read at F sees pre-edge table state; no same-cycle bypass of an update to the same index.
REQ-030 Latency: prediction combinational in F; misprediction penalty 2 cycles (D, E flushed).

Reset
REQ-031 rst=1 asynchronously: all counters = 2^(CNT_BITS-1)-1 (weakly not-taken; 01 for 2-bit), GHR=0, D/E metadata valid=0.
REQ-032 During and after reset no table or GHR update occurs until valid_E=1; outputs follow REQ-019..REQ-025 combinationally.
REQ-033 Reset asserted mid-operation discards in-flight metadata; no flushBranch from pre-reset instructions.

Verification
REQ-034 Reset, PCF=0x10, InstrF=BEQ imm +8 -> PCBPUSrc=0 (counter 01).
REQ-035 Same branch resolved taken twice (BranchE=1, TakenE=1) -> counter 11; next fetch at 0x10 -> PCBPUSrc=1, PCBPU=0x18.
REQ-036 Predicted-taken branch resolves not-taken, PCPlus4E=0x14 -> flushBranch=1, PCBPU=0x14, next-cycle valid_E=0.
REQ-037 JAL at PCF=0x40, imm -16 -> PCBPU=0x30, PCBPUSrc=1; table unchanged.
REQ-038 Saturation: four consecutive not-taken resolutions on one index -> counter stays 00; stall=1 with mispredict -> flushBranch=1.
REQ-039 GHR_BITS=2, ENTRIES=16: outcomes T,T then PCF=0x10 indexes entry 4 XOR 3 = 7.

Source files
------------

// File: rtl/branch_predictor.sv
// Fetch-stage branch predictor: table of saturating counters indexed by PC
// (optionally XOR global history), static JAL redirect, and execute-stage
// misprediction recovery with a 2-cycle penalty.
module branch_predictor #(
    parameter int WIDTH    = 32,
    parameter int ENTRIES  = 16,
    parameter int CNT_BITS = 2,
    parameter int GHR_BITS = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] PCF,
    input  logic [31:0]      InstrF,
    input  logic             stall,
    input  logic             BranchE,
    input  logic             TakenE,
    input  logic [WIDTH-1:0] PCTargetE,
    input  logic [WIDTH-1:0] PCPlus4E,
    output logic             PCBPUSrc,
    output logic [WIDTH-1:0] PCBPU,
    output logic             flushBranch
);

    localparam int IDX_W = $clog2(ENTRIES);
    localparam logic [CNT_BITS-1:0] CNT_RST = CNT_BITS'((1 << (CNT_BITS - 1)) - 1);
    localparam logic [CNT_BITS-1:0] CNT_MAX = '1;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;

    // Fetch-side decode and immediates
    logic             w_is_b;
    logic             w_is_jal;
    logic [12:0]      w_bimm13;
    logic [20:0]      w_jimm21;
    logic [WIDTH-1:0] w_bimm;
    logic [WIDTH-1:0] w_jimm;
    logic [IDX_W-1:0] w_ghr_ext;
    logic [IDX_W-1:0] w_idx_f;
    logic             w_pred_f;

    // Pattern history table
    logic [CNT_BITS-1:0] r_pht [ENTRIES];

    // Per-fetch metadata carried down the pipe
    logic             r_d_vld;
    logic             r_d_pt;
    logic [IDX_W-1:0] r_d_idx;
    logic             r_e_vld;
    logic             r_e_pt;
    logic [IDX_W-1:0] r_e_idx;

    // Execute-side resolution
    logic                w_upd;
    logic                w_mispred;
    logic [CNT_BITS-1:0] w_cnt_e;
    logic [CNT_BITS-1:0] w_cnt_nxt;

    assign w_is_b   = (InstrF[6:0] == OP_BRANCH);
    assign w_is_jal = (InstrF[6:0] == OP_JAL);
    assign w_bimm13 = {InstrF[31], InstrF[7], InstrF[30:25], InstrF[11:8], 1'b0};
    assign w_jimm21 = {InstrF[31], InstrF[19:12], InstrF[20], InstrF[30:21], 1'b0};
    assign w_bimm   = WIDTH'($signed(w_bimm13));
    assign w_jimm   = WIDTH'($signed(w_jimm21));

    assign w_idx_f  = PCF[IDX_W+1:2] ^ w_ghr_ext;
    // Read sees the pre-edge table; an update to the same entry lands next cycle.
    assign w_pred_f = r_pht[w_idx_f][CNT_BITS-1];

    // Only branches whose metadata survived to execute train the predictor.
    assign w_upd     = BranchE & r_e_vld;
    assign w_mispred = w_upd & (TakenE != r_e_pt);
    assign flushBranch = w_mispred;

    // Global history: shifted with each resolved branch outcome (non-speculative).
    generate
        if (GHR_BITS > 0) begin : g_ghr
            logic [GHR_BITS-1:0] r_ghr;

            // History shift register, updated only on a valid resolution
            always_ff @(posedge clk or posedge rst) begin
                if (rst)
                    r_ghr <= '0;
                else if (w_upd)
                    r_ghr <= GHR_BITS'({r_ghr, TakenE});
            end

            assign w_ghr_ext = IDX_W'(r_ghr);
        end else begin : g_no_ghr
            assign w_ghr_ext = '0;
        end
    endgenerate

    // Redirect select: execute-stage recovery beats any fetch-stage prediction
    always_comb begin
        PCBPUSrc = 1'b0;
        PCBPU    = '0;
        if (w_mispred) begin
            PCBPUSrc = 1'b1;
            PCBPU    = TakenE ? PCTargetE : PCPlus4E;
        end else if (w_is_jal) begin
            PCBPUSrc = 1'b1;
            PCBPU    = PCF + w_jimm;
        end else if (w_is_b && w_pred_f) begin
            PCBPUSrc = 1'b1;
            PCBPU    = PCF + w_bimm;
        end
    end

    // Saturating next value of the counter being trained
    always_comb begin
        w_cnt_e   = r_pht[r_e_idx];
        w_cnt_nxt = w_cnt_e;
        if (TakenE) begin
            if (w_cnt_e != CNT_MAX)
                w_cnt_nxt = w_cnt_e + 1'b1;
        end else begin
            if (w_cnt_e != '0)
                w_cnt_nxt = w_cnt_e - 1'b1;
        end
    end

    // Counter table: reset to weakly not-taken, trained at execute
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < ENTRIES; i++)
                r_pht[i] <= CNT_RST;
        end else if (w_upd) begin
            r_pht[r_e_idx] <= w_cnt_nxt;
        end
    end

    // F->D metadata: only conditional branches are marked valid; flush kills it
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_d_vld <= 1'b0;
            r_d_pt  <= 1'b0;
            r_d_idx <= '0;
        end else if (w_mispred) begin
            r_d_vld <= 1'b0;
        end else if (!stall) begin
            r_d_vld <= w_is_b;
            r_d_pt  <= w_pred_f;
            r_d_idx <= w_idx_f;
        end
    end

    // D->E metadata: bubble inserted on stall or flush
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_e_vld <= 1'b0;
            r_e_pt  <= 1'b0;
            r_e_idx <= '0;
        end else if (stall || w_mispred) begin
            r_e_vld <= 1'b0;
        end else begin
            r_e_vld <= r_d_vld;
            r_e_pt  <= r_d_pt;
            r_e_idx <= r_d_idx;
        end
    end

endmodule

// File: tb/tb_branch_predictor.sv
// Directed bench for branch_predictor: bimodal instance plus a gshare
// (GHR_BITS=2) instance sharing the same stimulus.
module tb_branch_predictor;

    localparam logic [31:0] NOP   = 32'h0000_0013;
    localparam logic [31:0] BEQ8  = 32'h0000_0463;  // beq x0,x0,+8
    localparam logic [31:0] JALM16 = 32'hFF1F_F06F; // jal x0,-16

    logic        clk;
    logic        rst;
    logic [31:0] PCF;
    logic [31:0] InstrF;
    logic        stall;
    logic        BranchE;
    logic        TakenE;
    logic [31:0] PCTargetE;
    logic [31:0] PCPlus4E;

    logic        src0, fl0, src1, fl1;
    logic [31:0] pcb0, pcb1;

    int checks   = 0;
    int failures = 0;
    logic f0, f1;

    branch_predictor #(.WIDTH(32), .ENTRIES(16), .CNT_BITS(2), .GHR_BITS(0)) dut (
        .clk(clk), .rst(rst), .PCF(PCF), .InstrF(InstrF), .stall(stall),
        .BranchE(BranchE), .TakenE(TakenE), .PCTargetE(PCTargetE), .PCPlus4E(PCPlus4E),
        .PCBPUSrc(src0), .PCBPU(pcb0), .flushBranch(fl0)
    );

    branch_predictor #(.WIDTH(32), .ENTRIES(16), .CNT_BITS(2), .GHR_BITS(2)) dut_g (
        .clk(clk), .rst(rst), .PCF(PCF), .InstrF(InstrF), .stall(stall),
        .BranchE(BranchE), .TakenE(TakenE), .PCTargetE(PCTargetE), .PCPlus4E(PCPlus4E),
        .PCBPUSrc(src1), .PCBPU(pcb1), .flushBranch(fl1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Fetch a branch, carry it to execute, resolve it; returns sampled flushes.
    task automatic resolve(input logic [31:0] pc, input logic taken,
                           output logic fl_b, output logic fl_g);
        PCF = pc; InstrF = BEQ8; BranchE = 1'b0;
        step();
        InstrF = NOP;
        step();
        BranchE = 1'b1; TakenE = taken; PCTargetE = pc + 32'd8; PCPlus4E = pc + 32'd4;
        #3;
        fl_b = fl0; fl_g = fl1;
        step();
        BranchE = 1'b0; TakenE = 1'b0;
    endtask

    // Present a fetch and let outputs settle (caller samples)
    task automatic fetch(input logic [31:0] pc, input logic [31:0] instr);
        PCF = pc; InstrF = instr; BranchE = 1'b0;
        #3;
    endtask

    initial begin
        rst = 1'b1; stall = 1'b0; PCF = 32'h0; InstrF = NOP;
        BranchE = 1'b1; TakenE = 1'b1; PCTargetE = 32'h0; PCPlus4E = 32'h0;
        step();
        chk("rst_flush", {31'b0, fl0}, 32'd0);
        chk("rst_src", {31'b0, src0}, 32'd0);
        step();
        rst = 1'b0; BranchE = 1'b0; TakenE = 1'b0;

        // Fresh weakly-not-taken counter: no redirect
        fetch(32'h10, BEQ8);
        chk("init_bpred", {31'b0, src0}, 32'd0);
        InstrF = NOP;
        step(); step(); step();

        // Train taken twice: 01 -> 10 -> 11
        resolve(32'h10, 1'b1, f0, f1);
        chk("train1_flush", {31'b0, f0}, 32'd1);
        resolve(32'h10, 1'b1, f0, f1);
        chk("train2_flush", {31'b0, f0}, 32'd0);
        fetch(32'h10, BEQ8);
        chk("taken_src", {31'b0, src0}, 32'd1);
        chk("taken_pc", pcb0, 32'h18);
        InstrF = NOP;
        step();

        // Predicted-taken branch resolves not-taken while another branch is at fetch
        PCF = 32'h10; InstrF = BEQ8;
        step();
        InstrF = NOP;
        step();
        PCF = 32'h10; InstrF = BEQ8;
        BranchE = 1'b1; TakenE = 1'b0; PCTargetE = 32'h18; PCPlus4E = 32'h14;
        #3;
        chk("mis_flush", {31'b0, fl0}, 32'd1);
        chk("mis_src", {31'b0, src0}, 32'd1);
        chk("mis_pc", pcb0, 32'h14);
        step();
        InstrF = NOP;
        #3;
        chk("e_bubble", {31'b0, fl0}, 32'd0);
        step();
        #3;
        chk("d_cleared", {31'b0, fl0}, 32'd0);
        step();
        BranchE = 1'b0;
        fetch(32'h10, BEQ8);
        chk("after_mis_src", {31'b0, src0}, 32'd1);
        InstrF = NOP;
        step();

        // JAL: static redirect, never trains the table
        fetch(32'h40, JALM16);
        chk("jal_src", {31'b0, src0}, 32'd1);
        chk("jal_pc", pcb0, 32'h30);
        step();
        InstrF = NOP;
        step();
        BranchE = 1'b1; TakenE = 1'b1;
        #3;
        chk("jal_no_flush", {31'b0, fl0}, 32'd0);
        step();
        BranchE = 1'b0; TakenE = 1'b0;
        fetch(32'h40, BEQ8);
        chk("jal_tbl_same", {31'b0, src0}, 32'd0);
        InstrF = NOP;
        step();

        // Saturation at zero: 10 -> 01 -> 00 -> 00 -> 00
        resolve(32'h10, 1'b0, f0, f1);
        chk("sat1_flush", {31'b0, f0}, 32'd1);
        resolve(32'h10, 1'b0, f0, f1);
        chk("sat2_flush", {31'b0, f0}, 32'd0);
        resolve(32'h10, 1'b0, f0, f1);
        resolve(32'h10, 1'b0, f0, f1);
        chk("sat4_flush", {31'b0, f0}, 32'd0);
        fetch(32'h10, BEQ8);
        chk("sat_src", {31'b0, src0}, 32'd0);
        InstrF = NOP;
        step();
        resolve(32'h10, 1'b1, f0, f1);   // 00 -> 01
        fetch(32'h10, BEQ8);
        chk("sat_up1_src", {31'b0, src0}, 32'd0);
        InstrF = NOP;
        step();
        resolve(32'h10, 1'b1, f0, f1);   // 01 -> 10
        chk("sat_up2_flush", {31'b0, f0}, 32'd1);
        fetch(32'h10, BEQ8);
        chk("sat_up2_src", {31'b0, src0}, 32'd1);
        InstrF = NOP;
        step();

        // Stall does not suppress a mispredict (counter 10 -> 01)
        PCF = 32'h10; InstrF = BEQ8;
        step();
        InstrF = NOP;
        step();
        stall = 1'b1; BranchE = 1'b1; TakenE = 1'b0; PCTargetE = 32'h18; PCPlus4E = 32'h14;
        #3;
        chk("stall_mis_flush", {31'b0, fl0}, 32'd1);
        chk("stall_mis_pc", pcb0, 32'h14);
        step();
        stall = 1'b0; BranchE = 1'b0;
        step();

        // Stall holds D and bubbles E; branch (pred NT) arrives one cycle late
        PCF = 32'h10; InstrF = BEQ8;
        step();
        stall = 1'b1; InstrF = NOP;
        step();
        BranchE = 1'b1; TakenE = 1'b1; PCTargetE = 32'h18; PCPlus4E = 32'h14;
        #3;
        chk("stall_bubble", {31'b0, fl0}, 32'd0);
        stall = 1'b0;
        step();
        #3;
        chk("stall_held_d", {31'b0, fl0}, 32'd1);
        step();
        BranchE = 1'b0; TakenE = 1'b0;

        // Reset mid-flight discards the in-flight branch
        PCF = 32'h20; InstrF = BEQ8;
        step();
        InstrF = NOP;
        step();
        BranchE = 1'b1; TakenE = 1'b1; PCTargetE = 32'h28; PCPlus4E = 32'h24;
        #1;
        chk("pre_rst_mis", {31'b0, fl0}, 32'd1);
        rst = 1'b1;
        #1;
        chk("rst_kills", {31'b0, fl0}, 32'd0);
        step();
        rst = 1'b0; BranchE = 1'b0; TakenE = 1'b0;
        step();

        // gshare: T,T at PC 0x1C trains entries 7 then 6; GHR=11 -> 0x10 maps to 4^3=7
        resolve(32'h1C, 1'b1, f0, f1);
        resolve(32'h1C, 1'b1, f0, f1);
        fetch(32'h10, BEQ8);
        chk("gshare_src", {31'b0, src1}, 32'd1);
        chk("gshare_pc", pcb1, 32'h18);
        chk("bimodal_src", {31'b0, src0}, 32'd0);
        InstrF = NOP;
        step();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
